// File: rtl/display_mux_4digit_if.sv
// Signal bundle between a digit source and the 4-digit display scanner.
// Ports: none; carries en/load/d0..d3/dp_in toward the scanner and
//        an/seg/dp/digit_sel back out to the display.
interface display_mux_4digit_if;
  logic       en;
  logic       load;
  logic [3:0] d0;
  logic [3:0] d1;
  logic [3:0] d2;
  logic [3:0] d3;
  logic [3:0] dp_in;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic [1:0] digit_sel;

  // Driver side: supplies digits and strobes, observes the display lines.
  modport master (
    output en, load, d0, d1, d2, d3, dp_in,
    input  an, seg, dp, digit_sel
  );

  // Scanner side.
  modport slave (
    input  en, load, d0, d1, d2, d3, dp_in,
    output an, seg, dp, digit_sel
  );
endinterface

// File: rtl/display_mux_4digit.sv
// Multiplexed 4-digit 7-segment scanner with hex decode, guard blanking
// between digits and optional leading-zero blanking.
// Ports: clk, reset (sync, active-high); bus.slave carries en, load, d0..d3,
//        dp_in in and an, seg, dp, digit_sel out (all outputs registered,
//        active-low display lines).
module display_mux_4digit #(
  parameter int REFRESH_DIV   = 100000,
  parameter int GUARD_CYCLES  = 2,
  parameter int BLANK_LEADING = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  display_mux_4digit_if.slave  bus
);

  localparam int CNT_MAX = (REFRESH_DIV > GUARD_CYCLES) ? REFRESH_DIV : GUARD_CYCLES;
  localparam int PW      = $clog2(CNT_MAX);
  localparam logic [PW-1:0] SHOW_TC  = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] GUARD_TC = (GUARD_CYCLES > 0) ? PW'(GUARD_CYCLES - 1) : '0;

  typedef enum logic {SHOW = 1'b0, GUARD = 1'b1} state_t;

  state_t        state, state_n;
  logic [PW-1:0] presc, presc_n;
  logic [1:0]    idx, idx_n;
  logic [3:0]    snap [4];
  logic [3:0]    snap_dp;

  logic [3:0]    lead_blank;
  logic [3:0]    cur_digit;
  logic [6:0]    cur_seg;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // A digit is a leading zero when it and every digit to its left are zero.
  // Digit 0 always shows so an all-zero value still reads "0".
  always_comb begin
    lead_blank    = 4'b0000;
    lead_blank[3] = (snap[3] == 4'h0);
    lead_blank[2] = lead_blank[3] && (snap[2] == 4'h0);
    lead_blank[1] = lead_blank[2] && (snap[1] == 4'h0);
    if (BLANK_LEADING == 0) lead_blank = 4'b0000;
  end

  always_comb begin
    cur_digit = snap[idx];
    cur_seg   = lead_blank[idx] ? 7'b1111111 : hex7(cur_digit);
  end

  // Next-state: en low parks the scanner at digit 0, start of SHOW.
  always_comb begin
    state_n = state;
    presc_n = presc + 1'b1;
    idx_n   = idx;
    if (!bus.en) begin
      state_n = SHOW;
      presc_n = '0;
      idx_n   = 2'd0;
    end else begin
      case (state)
        SHOW: begin
          if (presc == SHOW_TC) begin
            presc_n = '0;
            idx_n   = idx + 2'd1;
            state_n = (GUARD_CYCLES == 0) ? SHOW : GUARD;
          end
        end
        default: begin
          if (presc == GUARD_TC) begin
            presc_n = '0;
            state_n = SHOW;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= SHOW;
      presc   <= '0;
      idx     <= 2'd0;
      snap[0] <= 4'h0;
      snap[1] <= 4'h0;
      snap[2] <= 4'h0;
      snap[3] <= 4'h0;
      snap_dp <= 4'h0;
    end else begin
      state <= state_n;
      presc <= presc_n;
      idx   <= idx_n;
      // Capture is independent of en and the scan position.
      if (bus.load) begin
        snap[0] <= bus.d0;
        snap[1] <= bus.d1;
        snap[2] <= bus.d2;
        snap[3] <= bus.d3;
        snap_dp <= bus.dp_in;
      end
    end
  end

  // Display lines are a registered view of the current state/snapshot.
  always_ff @(posedge clk) begin
    if (reset || !bus.en) begin
      bus.an        <= 4'b1111;
      bus.seg       <= 7'b1111111;
      bus.dp        <= 1'b1;
      bus.digit_sel <= 2'd0;
    end else if (state == SHOW) begin
      bus.an        <= ~(4'b0001 << idx);
      bus.seg       <= cur_seg;
      bus.dp        <= ~snap_dp[idx];
      bus.digit_sel <= idx;
    end else begin
      bus.an        <= 4'b1111;
      bus.seg       <= 7'b1111111;
      bus.dp        <= 1'b1;
      bus.digit_sel <= idx;
    end
  end

endmodule
